// File: rtl/model_write_key_dot_if.sv
`default_nettype none
// ============================================================================
// Module  : model_write_key_dot_if
// Brief   : Control, key, memory-row and result bus of the write-key dot stage.
// Revision: 1.0 - initial release
// ============================================================================
interface model_write_key_dot_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
);
    logic                    START;
    logic                    READY;
    logic                    ERROR;
    logic [CONTROL_SIZE-1:0] SIZE_W_IN;
    logic [CONTROL_SIZE-1:0] SIZE_N_IN;
    logic                    K_IN_READY;
    logic                    K_IN_ENABLE;
    logic [DATA_SIZE-1:0]    K_IN;
    logic                    M_IN_READY;
    logic                    M_IN_ENABLE;
    logic [DATA_SIZE-1:0]    M_IN;
    logic                    DOT_OUT_ENABLE;
    logic [DATA_SIZE-1:0]    DOT_OUT;
    logic [CONTROL_SIZE-1:0] DOT_J_OUT;

    modport master (
        output START, SIZE_W_IN, SIZE_N_IN, K_IN_ENABLE, K_IN, M_IN_ENABLE, M_IN,
        input  READY, ERROR, K_IN_READY, M_IN_READY, DOT_OUT_ENABLE, DOT_OUT, DOT_J_OUT
    );

    modport slave (
        input  START, SIZE_W_IN, SIZE_N_IN, K_IN_ENABLE, K_IN, M_IN_ENABLE, M_IN,
        output READY, ERROR, K_IN_READY, M_IN_READY, DOT_OUT_ENABLE, DOT_OUT, DOT_J_OUT
    );
endinterface
`default_nettype wire

// File: rtl/model_write_key_dot.sv
`default_nettype none
// ============================================================================
// Module  : model_write_key_dot
// Brief   : Buffers write key k(t) and emits k . M[j,:] for every memory row j.
// Revision: 1.0 - initial release
// ============================================================================
module model_write_key_dot #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MAX_W        = 16
) (
    input  wire                  CLK,
    input  wire                  RST,
    model_write_key_dot_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        ROW  = 2'd2
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] c_one   = CONTROL_SIZE'(1);
    localparam logic [CONTROL_SIZE-1:0] c_max_w = CONTROL_SIZE'(MAX_W);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CONTROL_SIZE-1:0] r_size_w;
    logic [CONTROL_SIZE-1:0] r_size_n;
    logic [CONTROL_SIZE-1:0] r_index_i;
    logic [CONTROL_SIZE-1:0] r_index_j;
    logic [DATA_SIZE-1:0]    r_acc;
    logic [DATA_SIZE-1:0]    r_buf [MAX_W];
    logic                    r_ready;
    logic                    r_error;
    logic                    r_dot_en;
    logic [DATA_SIZE-1:0]    r_dot;
    logic [CONTROL_SIZE-1:0] r_dot_j;

    logic                    w_illegal;
    logic                    w_last_i;
    logic                    w_last_j;
    logic                    w_key_wr;
    logic                    w_mem_rd;
    logic [DATA_SIZE-1:0]    w_buf_rd;
    logic [DATA_SIZE-1:0]    w_prod;
    logic [DATA_SIZE-1:0]    w_acc_sum;

    assign w_illegal = (bus.SIZE_W_IN == '0) || (bus.SIZE_W_IN > c_max_w) ||
                       (bus.SIZE_N_IN == '0);
    assign w_last_i  = (r_index_i == r_size_w - c_one);
    assign w_last_j  = (r_index_j == r_size_n - c_one);
    assign w_key_wr  = (r_state == KEY) && bus.K_IN_ENABLE;
    assign w_mem_rd  = (r_state == ROW) && bus.M_IN_ENABLE;
    assign w_prod    = w_buf_rd * bus.M_IN;
    assign w_acc_sum = r_acc + w_prod;

    // Full-width index compare keeps every counter bit meaningful for any W.
    always_comb begin
        w_buf_rd = '0;
        for (int k = 0; k < MAX_W; k++) begin
            if (r_index_i == CONTROL_SIZE'(k)) begin
                w_buf_rd = r_buf[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < MAX_W; k++) begin : g_buf
            always_ff @(posedge CLK) begin
                if (w_key_wr && (r_index_i == CONTROL_SIZE'(k))) begin
                    r_buf[k] <= bus.K_IN;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.START && !w_illegal)         w_state_next = KEY;
            KEY:     if (w_key_wr && w_last_i)            w_state_next = ROW;
            ROW:     if (w_mem_rd && w_last_i && w_last_j) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_size_w  <= '0;
            r_size_n  <= '0;
            r_index_i <= '0;
            r_index_j <= '0;
            r_acc     <= '0;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
            r_dot_en  <= 1'b0;
            r_dot     <= '0;
            r_dot_j   <= '0;
        end else begin
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
            r_dot_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_size_w  <= bus.SIZE_W_IN;
                        r_size_n  <= bus.SIZE_N_IN;
                        r_index_i <= '0;
                        r_index_j <= '0;
                        r_acc     <= '0;
                        if (w_illegal) begin
                            r_ready <= 1'b1;
                            r_error <= 1'b1;
                        end
                    end
                end
                KEY: begin
                    if (w_key_wr) begin
                        r_index_i <= w_last_i ? '0 : r_index_i + c_one;
                    end
                end
                ROW: begin
                    if (w_mem_rd) begin
                        if (w_last_i) begin
                            r_dot     <= w_acc_sum;
                            r_dot_j   <= r_index_j;
                            r_dot_en  <= 1'b1;
                            r_acc     <= '0;
                            r_index_i <= '0;
                            if (w_last_j) begin
                                r_ready <= 1'b1;
                            end else begin
                                r_index_j <= r_index_j + c_one;
                            end
                        end else begin
                            r_acc     <= w_acc_sum;
                            r_index_i <= r_index_i + c_one;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.READY          = r_ready;
    assign bus.ERROR          = r_error;
    assign bus.K_IN_READY     = (r_state == KEY);
    assign bus.M_IN_READY     = (r_state == ROW);
    assign bus.DOT_OUT_ENABLE = r_dot_en;
    assign bus.DOT_OUT        = r_dot;
    assign bus.DOT_J_OUT      = r_dot_j;
endmodule
`default_nettype wire

// File: tb/tb_model_write_key_dot.sv
`default_nettype none
// ============================================================================
// Module  : tb_model_write_key_dot
// Brief   : Self-checking bench for model_write_key_dot against a dot-product model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_model_write_key_dot;
    localparam int DS = 64;
    localparam int CS = 64;
    localparam int MW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    model_write_key_dot_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

    model_write_key_dot #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .MAX_W(MW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DS-1:0] key_a [MW];
    logic [DS-1:0] mem_a [MW*4];

    int cyc = 0;
    int start_cyc, ready_cyc;
    int ready_cnt, error_cnt, rdot_cnt, kr_seen, mr_seen;
    logic [DS-1:0] dot_q [$];
    logic [CS-1:0] j_q [$];

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        if (!RST) begin
            if (bus.DOT_OUT_ENABLE) begin
                dot_q.push_back(bus.DOT_OUT);
                j_q.push_back(bus.DOT_J_OUT);
            end
            if (bus.READY) begin
                ready_cnt = ready_cnt + 1;
                ready_cyc = cyc;
                if (bus.DOT_OUT_ENABLE) rdot_cnt = rdot_cnt + 1;
            end
            if (bus.ERROR)      error_cnt = error_cnt + 1;
            if (bus.K_IN_READY) kr_seen   = kr_seen + 1;
            if (bus.M_IN_READY) mr_seen   = mr_seen + 1;
        end
    end

    function automatic logic [DS-1:0] ref_dot(input int w, input int j);
        logic [DS-1:0] s = '0;
        for (int i = 0; i < w; i++) s = s + key_a[i] * mem_a[j*w + i];
        return s;
    endfunction

    task automatic clear_mon();
        ready_cnt = 0; error_cnt = 0; rdot_cnt = 0; kr_seen = 0; mr_seen = 0;
        dot_q.delete(); j_q.delete();
    endtask

    task automatic do_start(input int w, input int n);
        @(negedge CLK);
        bus.SIZE_W_IN = CS'(w);
        bus.SIZE_N_IN = CS'(n);
        bus.START     = 1'b1;
        start_cyc     = cyc + 1;
        @(negedge CLK);
        bus.START     = 1'b0;
    endtask

    task automatic send_k(input logic [DS-1:0] v, input bit spur);
        int gap = spur ? $urandom_range(0, 3) : 0;
        int n = 0;
        repeat (gap) begin
            bus.M_IN_ENABLE = 1'b1;
            bus.M_IN = {$urandom, $urandom};
            @(negedge CLK);
        end
        bus.M_IN_ENABLE = 1'b0;
        while (!bus.K_IN_READY && n < 100) begin @(negedge CLK); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL k_ready_wait: K_IN_READY stayed %0b, required 1", bus.K_IN_READY);
        end
        bus.K_IN_ENABLE = 1'b1;
        bus.K_IN        = v;
        bus.M_IN_ENABLE = spur;
        bus.M_IN        = {$urandom, $urandom};
        @(negedge CLK);
        bus.K_IN_ENABLE = 1'b0;
        bus.M_IN_ENABLE = 1'b0;
    endtask

    task automatic send_m(input logic [DS-1:0] v, input bit spur);
        int gap = spur ? $urandom_range(0, 3) : 0;
        int n = 0;
        repeat (gap) begin
            bus.K_IN_ENABLE = 1'b1;
            bus.K_IN = {$urandom, $urandom};
            bus.START = 1'b1;
            bus.SIZE_W_IN = '0;
            @(negedge CLK);
        end
        bus.K_IN_ENABLE = 1'b0;
        bus.START = 1'b0;
        while (!bus.M_IN_READY && n < 100) begin @(negedge CLK); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL m_ready_wait: M_IN_READY stayed %0b, required 1", bus.M_IN_READY);
        end
        bus.M_IN_ENABLE = 1'b1;
        bus.M_IN        = v;
        bus.K_IN_ENABLE = spur;
        bus.K_IN        = {$urandom, $urandom};
        @(negedge CLK);
        bus.M_IN_ENABLE = 1'b0;
        bus.K_IN_ENABLE = 1'b0;
    endtask

    task automatic run_op(input int w, input int n, input bit spur, output int cycles);
        int t = 0;
        clear_mon();
        do_start(w, n);
        for (int i = 0; i < w; i++) send_k(key_a[i], spur);
        for (int e = 0; e < w*n; e++) send_m(mem_a[e], spur);
        while (ready_cnt == 0 && t < 100) begin @(negedge CLK); t++; end
        if (t >= 100) begin
            checks++; failures++;
            $display("FAIL ready_wait: READY count %0d, required 1", ready_cnt);
        end
        cycles = ready_cyc - start_cyc + 1;
    endtask

    task automatic load_basic();
        key_a[0] = 1; key_a[1] = 2; key_a[2] = 3;
        for (int e = 0; e < 6; e++) mem_a[e] = DS'(e + 4);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.READY, bus.ERROR, bus.K_IN_READY, bus.M_IN_READY, bus.DOT_OUT_ENABLE} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {bus.READY, bus.ERROR, bus.K_IN_READY, bus.M_IN_READY, bus.DOT_OUT_ENABLE});
        end
        checks++;
        if (bus.DOT_OUT !== '0 || bus.DOT_J_OUT !== '0) begin
            failures++;
            $display("FAIL reset_data: dot %0d j %0d, required 0 0", bus.DOT_OUT, bus.DOT_J_OUT);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic(input bit spur, input string tag);
        int cycles;
        load_basic();
        run_op(3, 2, spur, cycles);
        checks++;
        if (dot_q.size() !== 2) begin
            failures++;
            $display("FAIL %s_count: %0d results, required 2", tag, dot_q.size());
        end
        for (int j = 0; j < 2 && j < dot_q.size(); j++) begin
            checks++;
            if (dot_q[j] !== ref_dot(3, j) || j_q[j] !== CS'(j)) begin
                failures++;
                $display("FAIL %s_dot%0d: got %0d j=%0d, required %0d j=%0d",
                         tag, j, dot_q[j], j_q[j], ref_dot(3, j), j);
            end
        end
        checks++;
        if (rdot_cnt !== 1 || ready_cnt !== 1 || error_cnt !== 0) begin
            failures++;
            $display("FAIL %s_ready: ready %0d coincident %0d error %0d, required 1 1 0",
                     tag, ready_cnt, rdot_cnt, error_cnt);
        end
        if (!spur) begin
            checks++;
            if (cycles !== 10) begin
                failures++;
                $display("FAIL %s_latency: %0d cycles, required 10", tag, cycles);
            end
        end
    endtask

    task automatic test_overflow();
        int cycles;
        key_a[0] = 64'h8000_0000_0000_0000; key_a[1] = 1;
        mem_a[0] = 2; mem_a[1] = 5;
        run_op(2, 1, 1'b0, cycles);
        checks++;
        if (dot_q.size() !== 1 || dot_q[0] !== 64'd5) begin
            failures++;
            $display("FAIL overflow: %0d results first %0d, required 1 result 5",
                     dot_q.size(), dot_q.size() > 0 ? dot_q[0] : 64'd0);
        end
    endtask

    task automatic test_illegal();
        int ws [3] = '{0, MW + 1, 4};
        int ns [3] = '{2, 2, 0};
        for (int c = 0; c < 3; c++) begin
            clear_mon();
            do_start(ws[c], ns[c]);
            repeat (3) @(negedge CLK);
            checks++;
            if (ready_cnt !== 1 || error_cnt !== 1 || ready_cyc !== start_cyc) begin
                failures++;
                $display("FAIL illegal%0d_pulse: ready %0d error %0d at +%0d, required 1 1 +0",
                         c, ready_cnt, error_cnt, ready_cyc - start_cyc);
            end
            checks++;
            if (kr_seen !== 0 || mr_seen !== 0 || dot_q.size() !== 0) begin
                failures++;
                $display("FAIL illegal%0d_quiet: kready %0d mready %0d dots %0d, required 0 0 0",
                         c, kr_seen, mr_seen, dot_q.size());
            end
        end
    endtask

    task automatic test_boundary();
        int cycles;
        for (int i = 0; i < MW; i++) key_a[i] = 1;
        for (int e = 0; e < MW*3; e++) mem_a[e] = 1;
        run_op(MW, 3, 1'b0, cycles);
        checks++;
        if (dot_q.size() !== 3) begin
            failures++;
            $display("FAIL maxw_count: %0d results, required 3", dot_q.size());
        end
        for (int j = 0; j < 3 && j < dot_q.size(); j++) begin
            checks++;
            if (dot_q[j] !== 64'd16 || j_q[j] !== CS'(j)) begin
                failures++;
                $display("FAIL maxw_dot%0d: got %0d j=%0d, required 16 j=%0d", j, dot_q[j], j_q[j], j);
            end
        end
        key_a[0] = 7; mem_a[0] = 6;
        run_op(1, 1, 1'b0, cycles);
        checks++;
        if (dot_q.size() !== 1 || dot_q[0] !== 64'd42 || cycles !== 3) begin
            failures++;
            $display("FAIL minw: %0d results first %0d cycles %0d, required 1 42 3",
                     dot_q.size(), dot_q.size() > 0 ? dot_q[0] : 64'd0, cycles);
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        clear_mon();
        do_start(3, 2);
        for (int i = 0; i < 3; i++) send_k(key_a[i], 1'b0);
        for (int e = 0; e < 4; e++) send_m(mem_a[e], 1'b0);
        RST = 1'b1;
        #1;
        checks++;
        if ({bus.READY, bus.ERROR, bus.K_IN_READY, bus.M_IN_READY, bus.DOT_OUT_ENABLE} !== 5'b0 ||
            bus.DOT_OUT !== '0 || bus.DOT_J_OUT !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: ctrl %b dot %0d j %0d, required 0",
                     {bus.READY, bus.ERROR, bus.K_IN_READY, bus.M_IN_READY, bus.DOT_OUT_ENABLE},
                     bus.DOT_OUT, bus.DOT_J_OUT);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (ready_cnt !== 0 || dot_q.size() !== 1) begin
            failures++;
            $display("FAIL midreset_partial: ready %0d dots %0d, required 0 1", ready_cnt, dot_q.size());
        end
        test_basic(1'b0, "rerun");
    endtask

    task automatic test_random();
        int cycles, w, n;
        for (int r = 0; r < 4; r++) begin
            w = $urandom_range(1, MW);
            n = $urandom_range(1, 4);
            for (int i = 0; i < w; i++) key_a[i] = {$urandom, $urandom};
            for (int e = 0; e < w*n; e++) mem_a[e] = {$urandom, $urandom};
            run_op(w, n, r[0], cycles);
            checks++;
            if (dot_q.size() !== n) begin
                failures++;
                $display("FAIL rand%0d_count: %0d results, required %0d", r, dot_q.size(), n);
            end
            for (int j = 0; j < n && j < dot_q.size(); j++) begin
                checks++;
                if (dot_q[j] !== ref_dot(w, j) || j_q[j] !== CS'(j)) begin
                    failures++;
                    $display("FAIL rand%0d_dot%0d: got %h j=%0d, required %h j=%0d",
                             r, j, dot_q[j], j_q[j], ref_dot(w, j), j);
                end
            end
            if (r[0] == 1'b0) begin
                checks++;
                if (cycles !== 1 + w + n*w) begin
                    failures++;
                    $display("FAIL rand%0d_latency: %0d cycles, required %0d", r, cycles, 1 + w + n*w);
                end
            end
        end
    endtask

    initial begin
        bus.START = 1'b0; bus.SIZE_W_IN = '0; bus.SIZE_N_IN = '0;
        bus.K_IN_ENABLE = 1'b0; bus.K_IN = '0;
        bus.M_IN_ENABLE = 1'b0; bus.M_IN = '0;
        clear_mon();
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "gapped");
        test_overflow();
        test_illegal();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
